simple_threshold_trigger: RTL and testbench

- Downstream stage of the price x quantity notional multiplier in the simple_threshold datapath.
- Registers each 24-bit notional sample with its price and compares it against a programmable threshold.
- Issues one order per crossing on a valid/ready output, then enforces a cooldown and hysteresis re-arm.
- Its output feeds the order-formatting stage.

---
 rtl/simple_threshold_pkg.sv | 34 +++
 rtl/simple_threshold_if.sv | 30 +++
 rtl/simple_threshold_sat_cnt.sv | 42 ++++
 rtl/simple_threshold_trigger.sv | 155 +++++++++++++++
 tb/tb_simple_threshold_trigger.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/simple_threshold_pkg.sv
// rtl/simple_threshold_pkg.sv - shared widths, FSM states and order record for the threshold trigger
//
// Purpose: constants, state enum, order struct and the saturating re-arm level helper
//          used by every file of the simple_threshold trigger.
package simple_threshold_pkg;

  localparam int PRICE_W    = 16;
  localparam int QTY_W      = 8;
  localparam int NOTIONAL_W = PRICE_W + QTY_W;
  localparam int COOL_W     = 8;
  localparam int STAT_W     = 16;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2,
    DISARMED = 2'd3
  } state_e;

  typedef struct packed {
    logic [PRICE_W-1:0]    price;
    logic [NOTIONAL_W-1:0] notional;
  } order_t;

  // Threshold minus hysteresis, clamped at zero so a large margin never wraps
  // into a huge re-arm level.
  function automatic logic [NOTIONAL_W-1:0] rearm_level(
    input logic [NOTIONAL_W-1:0] thr,
    input logic [NOTIONAL_W-1:0] hyst
  );
    return (thr > hyst) ? (thr - hyst) : '0;
  endfunction

endpackage

// File: rtl/simple_threshold_if.sv
// rtl/simple_threshold_if.sv - sample input and order output handshakes of the threshold trigger
//
// Purpose: bundles the notional sample stream (in_*) and the order stream (ord_*).
// Modports:
//   master - the surrounding datapath: drives in_valid/in_notional/in_price and ord_ready
//   slave  - the trigger block: drives in_ready and ord_valid/ord_price/ord_notional
interface simple_threshold_if;
  import simple_threshold_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [NOTIONAL_W-1:0] in_notional;
  logic [PRICE_W-1:0]    in_price;

  logic                  ord_valid;
  logic                  ord_ready;
  logic [PRICE_W-1:0]    ord_price;
  logic [NOTIONAL_W-1:0] ord_notional;

  modport master (
    output in_valid, in_notional, in_price, ord_ready,
    input  in_ready, ord_valid, ord_price, ord_notional
  );

  modport slave (
    input  in_valid, in_notional, in_price, ord_ready,
    output in_ready, ord_valid, ord_price, ord_notional
  );

endinterface

// File: rtl/simple_threshold_sat_cnt.sv
// rtl/simple_threshold_sat_cnt.sv - saturating event counter with synchronous clear
//
// Purpose: counts single-cycle inc pulses, sticking at all-ones.
// Ports:
//   clk_i   - clock, rising edge
//   rst_n_i - synchronous active-low reset (clears count)
//   clr_i   - synchronous clear
//   inc_i   - count one event this cycle
//   cnt_o   - current count
module simple_threshold_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/simple_threshold_trigger.sv
// rtl/simple_threshold_trigger.sv - notional threshold trigger issuing one order per crossing
//
// Purpose: registers each notional sample, compares it against cfg_threshold,
//          issues one order per crossing, then applies cooldown and hysteresis re-arm.
// Optional feature: SIMPLE_THRESHOLD_STATS_EN builds the stat_fired/stat_suppressed
//          counters; when undefined both outputs are tied to zero.
// Ports:
//   ap_clk, ap_rst_n  - clock (rising) and synchronous active-low reset
//   bus (slave)       - in_* sample handshake and ord_* order handshake
//   cfg_enable        - 0 suppresses new orders
//   cfg_threshold     - inclusive fire level
//   cfg_hyst          - re-arm margin below threshold
//   cfg_cooldown      - suppression cycles after an order is accepted
//   stat_fired        - orders accepted
//   stat_suppressed   - at/above-threshold samples that did not fire
module simple_threshold_trigger #(
  parameter int PRICE_W    = simple_threshold_pkg::PRICE_W,
  parameter int NOTIONAL_W = simple_threshold_pkg::NOTIONAL_W,
  parameter int COOL_W     = simple_threshold_pkg::COOL_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  simple_threshold_if.slave     bus,
  input  logic                  cfg_enable,
  input  logic [NOTIONAL_W-1:0] cfg_threshold,
  input  logic [NOTIONAL_W-1:0] cfg_hyst,
  input  logic [COOL_W-1:0]     cfg_cooldown,
  output logic [15:0]           stat_fired,
  output logic [15:0]           stat_suppressed
);
  import simple_threshold_pkg::*;

  state_e                state_q, state_d;
  logic                  vld_q;
  logic [NOTIONAL_W-1:0] notional_q;
  logic [PRICE_W-1:0]    price_q;
  logic [COOL_W-1:0]     cnt_q, cnt_d;
  logic                  ord_valid_q, ord_valid_d;
  order_t                ord_q, ord_d;

  logic                  in_ready;
  logic                  hit;
  logic [NOTIONAL_W-1:0] rearm_lvl;

  assign in_ready  = (state_q != FIRE);
  assign rearm_lvl = rearm_level(cfg_threshold, cfg_hyst);
  assign hit       = vld_q && (notional_q >= cfg_threshold);

  // Stage 0: sample register; anything not accepted this edge leaves no sample.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_q      <= 1'b0;
      notional_q <= '0;
      price_q    <= '0;
    end else begin
      vld_q <= bus.in_valid && in_ready;
      if (bus.in_valid && in_ready) begin
        notional_q <= bus.in_notional;
        price_q    <= bus.in_price;
      end
    end
  end

  // Stage 1: state register and order holding registers.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= ARMED;
      cnt_q       <= '0;
      ord_valid_q <= 1'b0;
      ord_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ord_valid_q <= ord_valid_d;
      ord_q       <= ord_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ord_valid_d = ord_valid_q;
    ord_d       = ord_q;
    case (state_q)
      ARMED: begin
        if (hit && cfg_enable) begin
          state_d        = FIRE;
          ord_valid_d    = 1'b1;
          ord_d.price    = price_q;
          ord_d.notional = notional_q;
        end
      end
      FIRE: begin
        // The order stays up regardless of cfg_enable until it is taken.
        if (bus.ord_ready) begin
          ord_valid_d = 1'b0;
          cnt_d       = cfg_cooldown;
          state_d     = (cfg_cooldown != '0) ? COOLDOWN : DISARMED;
        end
      end
      COOLDOWN: begin
        cnt_d = cnt_q - 1'b1;
        // cnt_q of 0 cannot occur here normally; treat it as expired anyway.
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = DISARMED;
        end
      end
      DISARMED: begin
        if (vld_q && (notional_q < rearm_lvl)) begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d = ARMED;
      end
    endcase
  end

  assign bus.in_ready     = in_ready;
  assign bus.ord_valid    = ord_valid_q;
  assign bus.ord_price    = ord_q.price;
  assign bus.ord_notional = ord_q.notional;

`ifdef SIMPLE_THRESHOLD_STATS_EN
  logic fire_inc;
  logic sup_inc;

  assign fire_inc = (state_q == FIRE) && bus.ord_ready;
  // A hit is suppressed when disabled while armed, or anywhere after an order
  // until re-arm; a sample caught while an order is pending is simply dropped.
  assign sup_inc  = hit && (((state_q == ARMED) && !cfg_enable) ||
                            (state_q == COOLDOWN) || (state_q == DISARMED));

  simple_threshold_sat_cnt #(.W(STAT_W)) u_fired_cnt (
    .clk_i   (ap_clk),
    .rst_n_i (ap_rst_n),
    .clr_i   (1'b0),
    .inc_i   (fire_inc),
    .cnt_o   (stat_fired)
  );

  simple_threshold_sat_cnt #(.W(STAT_W)) u_sup_cnt (
    .clk_i   (ap_clk),
    .rst_n_i (ap_rst_n),
    .clr_i   (1'b0),
    .inc_i   (sup_inc),
    .cnt_o   (stat_suppressed)
  );
`else
  assign stat_fired      = '0;
  assign stat_suppressed = '0;
`endif

endmodule

// File: tb/tb_simple_threshold_trigger.sv
// tb/tb_simple_threshold_trigger.sv - self-checking bench for simple_threshold_trigger
module tb_simple_threshold_trigger;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        cfg_enable;
  logic [23:0] cfg_threshold;
  logic [23:0] cfg_hyst;
  logic [7:0]  cfg_cooldown;
  logic [15:0] stat_fired;
  logic [15:0] stat_suppressed;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  simple_threshold_if bus ();

  simple_threshold_trigger dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .bus             (bus.slave),
    .cfg_enable      (cfg_enable),
    .cfg_threshold   (cfg_threshold),
    .cfg_hyst        (cfg_hyst),
    .cfg_cooldown    (cfg_cooldown),
    .stat_fired      (stat_fired),
    .stat_suppressed (stat_suppressed)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an order is either pending, or we are counting down,
  // or waiting for a low sample, or armed.
  bit m_pending, m_disarmed;
  int m_cool;
  int m_price, m_not;
  int m_fired, m_sup;
  bit s_vld;
  int s_not, s_price;

  always @(posedge ap_clk) begin
    bit hit, nv;
    int rl, thr, nn, np;
    if (!ap_rst_n) begin
      m_pending = 0; m_disarmed = 0; m_cool = 0;
      m_price = 0; m_not = 0; m_fired = 0; m_sup = 0;
      s_vld = 0; s_not = 0; s_price = 0;
    end else begin
      thr = int'(cfg_threshold);
      rl  = (thr > int'(cfg_hyst)) ? thr - int'(cfg_hyst) : 0;
      hit = s_vld && (s_not >= thr);
      nv  = bus.in_valid && !m_pending;
      nn  = int'(bus.in_notional);
      np  = int'(bus.in_price);
      if (m_pending) begin
        if (bus.ord_ready) begin
          m_pending = 0;
          if (m_fired < 65535) m_fired++;
          if (cfg_cooldown != 0) m_cool = int'(cfg_cooldown);
          else m_disarmed = 1;
        end
      end else if (m_cool > 0) begin
        if (hit && m_sup < 65535) m_sup++;
        m_cool--;
        if (m_cool == 0) m_disarmed = 1;
      end else if (m_disarmed) begin
        if (hit && m_sup < 65535) m_sup++;
        if (s_vld && s_not < rl) m_disarmed = 0;
      end else if (hit) begin
        if (cfg_enable) begin
          m_pending = 1; m_price = s_price; m_not = s_not;
        end else if (m_sup < 65535) begin
          m_sup++;
        end
      end
      s_vld = nv; s_not = nn; s_price = np;
    end
  end

  always @(negedge ap_clk) begin
    if (chk_en) begin
      chk("in_ready", int'(bus.in_ready), m_pending ? 0 : 1);
      chk("ord_valid", int'(bus.ord_valid), int'(m_pending));
      chk("ord_price", int'(bus.ord_price), m_price);
      chk("ord_notional", int'(bus.ord_notional), m_not);
`ifdef SIMPLE_THRESHOLD_STATS_EN
      chk("stat_fired", int'(stat_fired), m_fired);
      chk("stat_suppressed", int'(stat_suppressed), m_sup);
`else
      chk("stat_fired", int'(stat_fired), 0);
      chk("stat_suppressed", int'(stat_suppressed), 0);
`endif
    end
  end

  task automatic step(input bit v, input int n, input int p, input bit r);
    bus.in_valid    = v;
    bus.in_notional = 24'(n);
    bus.in_price    = 16'(p);
    bus.ord_ready   = r;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle(input bit r, input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, r);
  endtask

  function automatic int stat_exp(input int v);
`ifdef SIMPLE_THRESHOLD_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  initial begin
    ap_rst_n = 0; cfg_enable = 0; cfg_threshold = 0; cfg_hyst = 0; cfg_cooldown = 0;
    step(0, 0, 0, 0);
    chk_en = 1;
    step(0, 0, 0, 0);
    chk("reset ord_valid", int'(bus.ord_valid), 0);
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset ord_notional", int'(bus.ord_notional), 0);

    ap_rst_n = 1; cfg_threshold = 1000; cfg_hyst = 100; cfg_cooldown = 3; cfg_enable = 1;
    step(1, 999, 10, 0);
    step(1, 1000, 11, 0);
    chk("no order for 999", int'(bus.ord_valid), 0);
    step(1, 2000, 12, 0);
    chk("first order valid", int'(bus.ord_valid), 1);
    chk("first order notional", int'(bus.ord_notional), 1000);
    chk("first order price", int'(bus.ord_price), 11);
    for (int i = 0; i < 5; i++) begin
      step(1, 3000 + i, 13, 0);
      chk("hold in_ready", int'(bus.in_ready), 0);
      chk("hold notional", int'(bus.ord_notional), 1000);
    end
    step(0, 0, 0, 1);
    chk("handshake clears valid", int'(bus.ord_valid), 0);
    idle(0, 2);
    step(1, 950, 14, 0);
    step(1, 899, 15, 0);
    step(1, 1200, 16, 0);
    chk("950 no rearm fire", int'(bus.ord_valid), 0);
    step(0, 0, 0, 0);
    chk("second order valid", int'(bus.ord_valid), 1);
    chk("second order notional", int'(bus.ord_notional), 1200);
    step(0, 0, 0, 1);
    idle(0, 3);
    step(1, 800, 17, 0);
    step(0, 0, 0, 0);

    cfg_enable = 0; cfg_threshold = 50; cfg_hyst = 200; cfg_cooldown = 0; cfg_enable = 1;
    step(1, 60, 20, 1);
    step(0, 0, 0, 1);
    chk("third order notional", int'(bus.ord_notional), 60);
    step(0, 0, 0, 1);
    step(1, 10, 21, 1);
    idle(1, 2);
    chk("10 no order", int'(bus.ord_valid), 0);
    chk("fired after three", int'(stat_fired), stat_exp(3));
    chk("10 not suppressed", int'(stat_suppressed), stat_exp(0));
    step(1, 70, 22, 1);
    idle(1, 2);
    chk("stays disarmed", int'(bus.ord_valid), 0);
    chk("70 suppressed", int'(stat_suppressed), stat_exp(1));

    ap_rst_n = 0;
    idle(0, 2);
    ap_rst_n = 1; cfg_enable = 0; cfg_threshold = 1000; cfg_hyst = 100; cfg_cooldown = 3;
    for (int i = 0; i < 3; i++) step(1, 5000, 30, 0);
    idle(0, 2);
    chk("disabled no order", int'(bus.ord_valid), 0);
    chk("disabled suppressed", int'(stat_suppressed), stat_exp(3));

    cfg_enable = 1;
    step(1, 5000, 31, 0);
    step(0, 0, 0, 0);
    chk("pre-reset order", int'(bus.ord_valid), 1);
    ap_rst_n = 0;
    step(0, 0, 0, 0);
    chk("reset drops order", int'(bus.ord_valid), 0);
    chk("reset clears fired", int'(stat_fired), 0);
    chk("reset clears suppressed", int'(stat_suppressed), 0);
    ap_rst_n = 1;
    step(1, 1500, 32, 0);
    step(0, 0, 0, 0);
    chk("armed after reset", int'(bus.ord_notional), 1500);
    step(0, 0, 0, 1);
    idle(0, 5);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
